// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline-control bundle between the execute-stage hazard controller and the pipe it steers.
interface ex_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [2:0]       id_rs;
  logic             id_rs_used;
  logic [2:0]       id_rt;
  logic             id_rt_used;
  logic             ex_valid;
  logic             ex_mem_read;
  logic [2:0]       ex_rd;
  logic             br_tkn;
  logic             ex_halt;
  logic             mem_busy;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_write_en;
  logic             ex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           ex_valid, ex_mem_read, ex_rd, br_tkn, ex_halt, mem_busy,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_flush,
           exmem_write_en, ex_flush, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           ex_valid, ex_mem_read, ex_rd, br_tkn, ex_halt, mem_busy,
    output pc_write_en, ifid_write_en, ifid_flush, idex_flush,
           exmem_write_en, ex_flush, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: load-use bubbles, branch squash, memory freeze, HALT latch.
// Control outputs react combinationally in the same cycle; state and counters are registered.
module ex_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned LU_BUBBLES   = 1,
  parameter int unsigned CNT_W        = 16
) (
  input logic             clk,
  input logic             rst,
  ex_hazard_ctrl_if.slave bus
);
  localparam int unsigned MAXC = (FLUSH_CYCLES > LU_BUBBLES) ? FLUSH_CYCLES : LU_BUBBLES;
  localparam int unsigned BW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, HALTED} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    bub_q, bub_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             hz;

  assign hz = bus.id_valid & bus.ex_valid & bus.ex_mem_read &
              ((bus.id_rs_used & (bus.id_rs == bus.ex_rd)) |
               (bus.id_rt_used & (bus.id_rt == bus.ex_rd)));

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

  always_comb begin
    state_d            = state_q;
    bub_d              = bub_q;
    stall_d            = stall_q;
    flush_d            = flush_q;
    bus.pc_write_en    = 1'b1;
    bus.ifid_write_en  = 1'b1;
    bus.ifid_flush     = 1'b0;
    bus.idex_flush     = 1'b0;
    bus.exmem_write_en = 1'b1;
    bus.ex_flush       = 1'b0;
    bus.halted         = 1'b0;

    if (rst) begin
      bus.pc_write_en    = 1'b0;
      bus.ifid_write_en  = 1'b0;
      bus.exmem_write_en = 1'b0;
      bus.ifid_flush     = 1'b1;
      bus.idex_flush     = 1'b1;
      bus.ex_flush       = 1'b1;
      state_d            = RUN;
      bub_d              = '0;
      stall_d            = '0;
      flush_d            = '0;
    end else if (state_q == HALTED) begin
      bus.pc_write_en    = 1'b0;
      bus.ifid_write_en  = 1'b0;
      bus.exmem_write_en = 1'b0;
      bus.halted         = 1'b1;
    end else if (bus.mem_busy) begin
      // Freeze everything; pending events are re-evaluated once memory frees up.
      bus.pc_write_en    = 1'b0;
      bus.ifid_write_en  = 1'b0;
      bus.exmem_write_en = 1'b0;
    end else begin
      case (state_q)
        FLUSH: begin
          bus.ifid_flush = 1'b1;
          bus.idex_flush = 1'b1;
          if (bub_q <= BW'(1)) begin
            state_d = RUN;
            bub_d   = '0;
          end else begin
            bub_d = bub_q - BW'(1);
          end
        end
        RUN, LU_STALL: begin
          if (bus.br_tkn && bus.ex_valid) begin
            // Redirect: any in-progress load-use stall belongs to the wrong path.
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            flush_d        = (flush_q == '1) ? flush_q : flush_q + CNT_W'(1);
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              bub_d   = BW'(FLUSH_CYCLES - 1);
            end else begin
              state_d = RUN;
              bub_d   = '0;
            end
          end else if (bus.ex_halt && bus.ex_valid) begin
            bus.pc_write_en   = 1'b0;
            bus.ifid_write_en = 1'b0;
            bus.idex_flush    = 1'b1;
            state_d           = HALTED;
            bub_d             = '0;
          end else if ((state_q == LU_STALL) || hz) begin
            bus.pc_write_en   = 1'b0;
            bus.ifid_write_en = 1'b0;
            bus.idex_flush    = 1'b1;
            stall_d           = (stall_q == '1) ? stall_q : stall_q + CNT_W'(1);
            if (state_q == LU_STALL) begin
              if (bub_q <= BW'(1)) begin
                state_d = RUN;
                bub_d   = '0;
              end else begin
                bub_d = bub_q - BW'(1);
              end
            end else if (LU_BUBBLES > 1) begin
              state_d = LU_STALL;
              bub_d   = BW'(LU_BUBBLES - 1);
            end
          end
        end
        default: begin
          state_d = RUN;
          bub_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      bub_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench: two controller configurations share one stimulus stream and are
// compared each cycle against a remaining-cycles reference model.
module tb_ex_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs_used, id_rt_used, ex_valid, ex_mem_read, br_tkn, ex_halt, mem_busy;
  logic [2:0] id_rs, id_rt, ex_rd;

  int n_cmp = 0;
  int n_bad = 0;

  int fc_p[2]  = '{1, 3};
  int lb_p[2]  = '{1, 2};
  int cw_p[2]  = '{2, 4};
  int m_halt[2];
  int m_lu[2];
  int m_fl[2];
  int m_scnt[2];
  int m_fcnt[2];

  ex_hazard_ctrl_if #(.CNT_W(2)) if0 ();
  ex_hazard_ctrl_if #(.CNT_W(4)) if1 ();

  assign if0.id_valid = id_valid;       assign if1.id_valid = id_valid;
  assign if0.id_rs = id_rs;             assign if1.id_rs = id_rs;
  assign if0.id_rs_used = id_rs_used;   assign if1.id_rs_used = id_rs_used;
  assign if0.id_rt = id_rt;             assign if1.id_rt = id_rt;
  assign if0.id_rt_used = id_rt_used;   assign if1.id_rt_used = id_rt_used;
  assign if0.ex_valid = ex_valid;       assign if1.ex_valid = ex_valid;
  assign if0.ex_mem_read = ex_mem_read; assign if1.ex_mem_read = ex_mem_read;
  assign if0.ex_rd = ex_rd;             assign if1.ex_rd = ex_rd;
  assign if0.br_tkn = br_tkn;           assign if1.br_tkn = br_tkn;
  assign if0.ex_halt = ex_halt;         assign if1.ex_halt = ex_halt;
  assign if0.mem_busy = mem_busy;       assign if1.mem_busy = mem_busy;

  ex_hazard_ctrl #(.FLUSH_CYCLES(1), .LU_BUBBLES(1), .CNT_W(2)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  ex_hazard_ctrl #(.FLUSH_CYCLES(3), .LU_BUBBLES(2), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  function automatic bit m_hz();
    return id_valid && ex_valid && ex_mem_read &&
           ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
  endfunction

  // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, ex_flush, halted}
  function automatic logic [6:0] m_out(input int d);
    if (rst)                           return 7'b0011010;
    if (m_halt[d] != 0)                return 7'b0000001;
    if (mem_busy)                      return 7'b0000000;
    if (m_fl[d] > 0)                   return 7'b1111100;
    if (br_tkn && ex_valid)            return 7'b1111100;
    if (ex_halt && ex_valid)           return 7'b0001100;
    if (m_lu[d] > 0 || m_hz())         return 7'b0001100;
    return 7'b1100100;
  endfunction

  function automatic int sat_inc(input int v, input int w);
    return (v >= (1 << w) - 1) ? v : v + 1;
  endfunction

  task automatic m_update(input int d);
    if (rst) begin
      m_halt[d] = 0; m_lu[d] = 0; m_fl[d] = 0; m_scnt[d] = 0; m_fcnt[d] = 0;
    end else if (m_halt[d] != 0 || mem_busy) begin
    end else if (m_fl[d] > 0) begin
      m_fl[d] = m_fl[d] - 1;
    end else if (br_tkn && ex_valid) begin
      m_fcnt[d] = sat_inc(m_fcnt[d], cw_p[d]);
      m_lu[d]   = 0;
      m_fl[d]   = fc_p[d] - 1;
    end else if (ex_halt && ex_valid) begin
      m_halt[d] = 1;
      m_lu[d]   = 0;
    end else if (m_lu[d] > 0) begin
      m_scnt[d] = sat_inc(m_scnt[d], cw_p[d]);
      m_lu[d]   = m_lu[d] - 1;
    end else if (m_hz()) begin
      m_scnt[d] = sat_inc(m_scnt[d], cw_p[d]);
      m_lu[d]   = lb_p[d] - 1;
    end
  endtask

  task automatic check_cycle(input string tag);
    for (int d = 0; d < 2; d++) begin
      logic [6:0] exp_o, got_o;
      int got_s, got_f;
      exp_o = m_out(d);
      if (d == 0) begin
        got_o = {if0.pc_write_en, if0.ifid_write_en, if0.ifid_flush, if0.idex_flush,
                 if0.exmem_write_en, if0.ex_flush, if0.halted};
        got_s = int'(if0.stall_cnt);
        got_f = int'(if0.flush_cnt);
      end else begin
        got_o = {if1.pc_write_en, if1.ifid_write_en, if1.ifid_flush, if1.idex_flush,
                 if1.exmem_write_en, if1.ex_flush, if1.halted};
        got_s = int'(if1.stall_cnt);
        got_f = int'(if1.flush_cnt);
      end
      n_cmp++;
      assert (got_o === exp_o) else begin
        n_bad++; $error("FAIL %s dut%0d ctl observed=%b expected=%b", tag, d, got_o, exp_o);
      end
      n_cmp++;
      assert (got_s === m_scnt[d]) else begin
        n_bad++; $error("FAIL %s dut%0d stall_cnt observed=%0d expected=%0d", tag, d, got_s, m_scnt[d]);
      end
      n_cmp++;
      assert (got_f === m_fcnt[d]) else begin
        n_bad++; $error("FAIL %s dut%0d flush_cnt observed=%0d expected=%0d", tag, d, got_f, m_fcnt[d]);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++; $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++; $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Inputs are set just after a falling edge; check mid-low-phase, then advance the model.
  task automatic step(input string tag);
    #2;
    check_cycle(tag);
    m_update(0);
    m_update(1);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd = 0; br_tkn = 0; ex_halt = 0; mem_busy = 0;
  endtask

  task automatic set_hazard();
    id_valid = 1; id_rs = 3'd3; id_rs_used = 1; ex_valid = 1; ex_mem_read = 1; ex_rd = 3'd3;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step("reset");
    step("reset");
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    for (int d = 0; d < 2; d++) begin
      m_halt[d] = 0; m_lu[d] = 0; m_fl[d] = 0; m_scnt[d] = 0; m_fcnt[d] = 0;
    end
    @(negedge clk);

    // Reset and default RUN
    do_reset();
    #2;
    check_bit("rst_pc_we", if0.pc_write_en, 1'b1);
    check_bit("rst_ifid_flush", if0.ifid_flush, 1'b0);
    check_int("rst_stall_cnt", int'(if0.stall_cnt), 0);
    #0;
    step("run_idle");

    // Single load-use hazard
    set_hazard();
    #2;
    check_bit("lu_pc_we", if0.pc_write_en, 1'b0);
    check_bit("lu_idex_flush", if0.idex_flush, 1'b1);
    step("lu_hit");
    idle_inputs();
    #2;
    check_bit("lu_after_pc_we", if0.pc_write_en, 1'b1);
    check_int("lu_stall_cnt", int'(if0.stall_cnt), 1);
    step("lu_after");
    step("lu_drain");

    // Branch and hazard together: branch wins
    do_reset();
    set_hazard();
    br_tkn = 1;
    #2;
    check_bit("br_pc_we", if0.pc_write_en, 1'b1);
    check_bit("br_ifid_flush", if0.ifid_flush, 1'b1);
    step("br_hz");
    idle_inputs();
    #2;
    check_int("br_flush_cnt", int'(if0.flush_cnt), 1);
    check_int("br_stall_cnt", int'(if0.stall_cnt), 0);
    for (int i = 0; i < 3; i++) step("br_tail");

    // Memory busy holds a pending hazard
    do_reset();
    set_hazard();
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check_bit("busy_pc_we", if0.pc_write_en, 1'b0);
      check_bit("busy_idex_flush", if0.idex_flush, 1'b0);
      step("busy");
    end
    mem_busy = 0;
    step("busy_release");
    idle_inputs();
    #2;
    check_int("busy_stall_cnt", int'(if0.stall_cnt), 1);
    step("busy_after");
    step("busy_drain");

    // HALT retires then freezes until reset
    do_reset();
    ex_valid = 1;
    ex_halt = 1;
    #2;
    check_bit("halt_exmem_we", if0.exmem_write_en, 1'b1);
    step("halt");
    for (int i = 0; i < 4; i++) begin
      set_hazard();
      br_tkn = 1'($urandom_range(0, 1));
      ex_halt = 1'($urandom_range(0, 1));
      #2;
      check_bit("halted", if0.halted, 1'b1);
      step("halted_hold");
    end
    rst = 1;
    idle_inputs();
    step("halt_rst");
    rst = 0;
    #2;
    check_bit("halt_cleared", if0.halted, 1'b0);
    step("halt_cleared");

    // Stall counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_hazard();
      step("sat_hz");
      idle_inputs();
      step("sat_gap");
    end
    #2;
    check_int("sat_stall_cnt", int'(if0.stall_cnt), 3);
    step("sat_end");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) < 2);
      id_valid    = 1'($urandom_range(0, 3) != 0);
      id_rs       = 3'($urandom_range(0, 2));
      id_rt       = 3'($urandom_range(0, 2));
      id_rs_used  = 1'($urandom_range(0, 1));
      id_rt_used  = 1'($urandom_range(0, 1));
      ex_valid    = 1'($urandom_range(0, 3) != 0);
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_rd       = 3'($urandom_range(0, 2));
      br_tkn      = ($urandom_range(0, 99) < 12);
      ex_halt     = ($urandom_range(0, 99) < 3);
      mem_busy    = ($urandom_range(0, 99) < 25);
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
